acq_window_sched: RTL and testbench
===================================

// Module: acq_window_sched
// PURPOSE
//  Sequences the pulse-counter datapath: clears the counters, opens a fixed-length count window, and waits for counter done.
//  It then issues a one-cycle snapshot strobe so the rocket readout latches a coherent count frame.
//  Sits between the rocket readout (frame strobe source, snapshot consumer) and the pulse counters (cnt_clr/cnt_start/cnt_done).
//  Flags frame overruns and missing counter-done as sticky errors for housekeeping.
// PARAMETERS
//  WIN_CYCLES  50000  count-window length in clk50 cycles (1 ms); legal 1..2^20-1
//  CLR_CYCLES  2      cnt_clr pulse length in cycles; legal 1..15
//  DONE_TMO    255    max cycles waited for cnt_done before timeout; legal 1..255
//  STIM_DIV    500    stim_pulse period in cycles (ACQ_SEQ_STIM_EN only); legal 2..65535
// PORTS
//  clk50         in   1  50 MHz system clock
//  gse_resetn    in   1  asynchronous, active-low reset
//  enable        in   1  level; 0 aborts and holds IDLE
//  free_run      in   1  level; 1 = back-to-back windows without frame_strobe
//  frame_strobe  in   1  1-cycle pulse from readout, requests a window
//  cnt_done      in   1  pulse counters finished accumulating
//  stim_cmd      in   1  synchronized stimulus command, active-high
//  err_clr       in   1  1-cycle pulse clears sticky errors
//  cnt_clr       out  1  counter clear, high during CLEAR
//  cnt_start     out  1  counter enable, high during COUNT
//  snap          out  1  1-cycle strobe: counts valid, latch now
//  seq_num       out  8  window sequence number, increments with snap
//  busy          out  1  high in any state except IDLE
//  err_overrun   out  1  sticky: frame_strobe arrived while busy
//  err_timeout   out  1  sticky: cnt_done absent within DONE_TMO
//  stim_pulse    out  1  1-cycle stimulus pulse (0 when macro off)
// BEHAVIOUR
//  Reset: all outputs 0, seq_num=0, state IDLE, all counters 0.
//  States: IDLE -> CLEAR -> COUNT -> WAIT_DONE -> SNAP -> (IDLE | CLEAR).
//  IDLE: enable=1 and (frame_strobe=1 or free_run=1) -> CLEAR next cycle.
//  CLEAR: cnt_clr=1 for exactly CLR_CYCLES cycles -> COUNT.
//  COUNT: cnt_start=1 for exactly WIN_CYCLES cycles -> WAIT_DONE.
//  WAIT_DONE: cnt_start=0. cnt_done=1 -> SNAP next cycle.
//   After DONE_TMO cycles without cnt_done: set err_timeout -> IDLE, no snap, seq_num unchanged.
//  SNAP: snap=1 for one cycle; seq_num increments on entry, so the new value is visible while snap=1.
//   seq_num wraps 255 -> 0.
//   Next state is CLEAR if enable & (free_run | frame_strobe this cycle), else IDLE.
//  Latency: frame_strobe in cycle 0 -> cnt_clr in cycles 1..CLR_CYCLES.
//   cnt_start follows in the next WIN_CYCLES cycles.
//   snap comes one cycle after cnt_done is sampled in WAIT_DONE.
//  frame_strobe while busy (CLEAR/COUNT/WAIT_DONE): set err_overrun; the strobe is dropped, not queued.
//  enable=0 in any state: next cycle IDLE; cnt_clr, cnt_start and snap drop to 0; the aborted window produces no snap.
//  cnt_done outside WAIT_DONE: ignored.
//  err_clr and a new error event in the same cycle: the error wins (flag stays 1).
//  Window counter is 20 bits and counts down; no arithmetic overflow is possible for legal parameters.
// CONFIGURATION
//  ACQ_SEQ_STIM_EN defined:
//   While state=COUNT and stim_cmd=1, stim_pulse pulses high for 1 cycle every STIM_DIV cycles.
//   The first pulse comes STIM_DIV cycles after COUNT entry or after the stim_cmd rise, whichever is later.
//   The divider resets whenever that condition is false.
//  ACQ_SEQ_STIM_EN undefined: stim_pulse tied 0; no divider logic is synthesized.
// TESTING  (WIN_CYCLES=10, CLR_CYCLES=2, DONE_TMO=8, STIM_DIV=4)
//  1. enable=1; frame_strobe at cycle 0; cnt_done=1 at cycle 13
//     -> cnt_clr cycles 1-2; cnt_start cycles 3-12; snap at cycle 14 with seq_num=1.
//  2. free_run=1, cnt_done held 1 -> continuous windows, snap every 14 cycles; seq_num wraps 255->0 after 256 windows.
//  3. cnt_done held 0 -> err_timeout=1 at WAIT_DONE+8, return to IDLE, no snap; err_clr pulse -> err_timeout=0.
//  4. frame_strobe during COUNT -> err_overrun=1; no extra window follows.
//  5. enable dropped mid-COUNT -> cnt_start=0 next cycle, busy=0, no snap.
//     Assert gse_resetn low mid-CLEAR -> all outputs 0 immediately.
//  6. ACQ_SEQ_STIM_EN, stim_cmd=1 -> stim_pulse at COUNT cycles 4 and 8 only.
//     Without the macro -> stim_pulse stays 0.

Source files
------------

// File: rtl/acq_window_sched.sv
// ---------------------------------------------------------------------------
// acq_window_sched
//   Sequencer for the pulse-counter datapath. For every requested window it
//   clears the counters, runs a fixed-length count window, waits for the
//   counters to report done, and then emits a one-cycle snapshot strobe with
//   an incrementing sequence number so the rocket readout can latch a
//   coherent count frame. Frame overruns and missing counter-done are
//   reported as sticky error flags.
//
//   Optional feature macro: ACQ_SEQ_STIM_EN
//     defined   -> stimulus divider producing stim_pulse during COUNT
//     undefined -> stim_pulse tied low, no divider logic
//
// Ports
//   clk50        in   system clock (50 MHz)
//   gse_resetn   in   asynchronous active-low reset
//   enable       in   level, 0 aborts any window and holds IDLE
//   free_run     in   level, 1 = back-to-back windows without frame_strobe
//   frame_strobe in   1-cycle window request from the readout
//   cnt_done     in   counters finished accumulating
//   stim_cmd     in   synchronized stimulus command
//   err_clr      in   1-cycle pulse clearing the sticky errors
//   cnt_clr      out  counter clear, high during CLEAR
//   cnt_start    out  counter enable, high during COUNT
//   snap         out  1-cycle "counts valid, latch now" strobe
//   seq_num      out  [7:0] window sequence number, visible with snap
//   busy         out  high in every state except IDLE
//   err_overrun  out  sticky: frame_strobe while a window was in progress
//   err_timeout  out  sticky: cnt_done missing within DONE_TMO cycles
//   stim_pulse   out  1-cycle stimulus pulse
// ---------------------------------------------------------------------------
module acq_window_sched #(
  parameter int unsigned WIN_CYCLES = 50000,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned DONE_TMO   = 255,
  parameter int unsigned STIM_DIV   = 500
) (
  input  logic       clk50,
  input  logic       gse_resetn,
  input  logic       enable,
  input  logic       free_run,
  input  logic       frame_strobe,
  input  logic       cnt_done,
  input  logic       stim_cmd,
  input  logic       err_clr,
  output logic       cnt_clr,
  output logic       cnt_start,
  output logic       snap,
  output logic [7:0] seq_num,
  output logic       busy,
  output logic       err_overrun,
  output logic       err_timeout,
  output logic       stim_pulse
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_COUNT     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_SNAP      = 3'd4
  } state_t;

  // The shared down-counter is loaded with (length - 1) on state entry, so a
  // state lasts exactly "length" cycles when it exits on counter == 0.
  localparam logic [19:0] CLR_LOAD = 20'(CLR_CYCLES - 1);
  localparam logic [19:0] WIN_LOAD = 20'(WIN_CYCLES - 1);
  localparam logic [19:0] TMO_LOAD = 20'(DONE_TMO - 1);

  state_t      state_r, state_nxt;
  logic [19:0] cnt_r, cnt_nxt;
  logic        set_timeout_s;
  logic        set_overrun_s;
  logic        cnt_clr_r, cnt_start_r, snap_r, busy_r;
  logic        err_overrun_r, err_timeout_r;
  logic [7:0]  seq_num_r;

  // Next-state, window-counter and error-event decode.
  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_r;
    set_timeout_s = 1'b0;
    set_overrun_s = frame_strobe &&
                    ((state_r == S_CLEAR) || (state_r == S_COUNT) ||
                     (state_r == S_WAIT_DONE));
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (frame_strobe || free_run) begin
            state_nxt = S_CLEAR;
            cnt_nxt   = CLR_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_CLEAR: begin
          if (cnt_r == 20'd0) begin
            state_nxt = S_COUNT;
            cnt_nxt   = WIN_LOAD;
          end else begin
            cnt_nxt = cnt_r - 20'd1;
          end
        end
        S_COUNT: begin
          if (cnt_r == 20'd0) begin
            state_nxt = S_WAIT_DONE;
            cnt_nxt   = TMO_LOAD;
          end else begin
            cnt_nxt = cnt_r - 20'd1;
          end
        end
        S_WAIT_DONE: begin
          if (cnt_done) begin
            state_nxt = S_SNAP;
          end else if (cnt_r == 20'd0) begin
            state_nxt     = S_IDLE;
            set_timeout_s = 1'b1;
          end else begin
            cnt_nxt = cnt_r - 20'd1;
          end
        end
        S_SNAP: begin
          // A strobe arriving in SNAP is accepted as the next request.
          if (free_run || frame_strobe) begin
            state_nxt = S_CLEAR;
            cnt_nxt   = CLR_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, counter and registered output decode of the next state.
  always_ff @(posedge clk50 or negedge gse_resetn) begin
    if (!gse_resetn) begin
      state_r       <= S_IDLE;
      cnt_r         <= 20'd0;
      cnt_clr_r     <= 1'b0;
      cnt_start_r   <= 1'b0;
      snap_r        <= 1'b0;
      busy_r        <= 1'b0;
      seq_num_r     <= 8'd0;
      err_overrun_r <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      cnt_clr_r   <= (state_nxt == S_CLEAR);
      cnt_start_r <= (state_nxt == S_COUNT);
      snap_r      <= (state_nxt == S_SNAP);
      busy_r      <= (state_nxt != S_IDLE);
      if (state_nxt == S_SNAP) begin
        seq_num_r <= seq_num_r + 8'd1;
      end
      // A new error event dominates a simultaneous clear.
      err_overrun_r <= set_overrun_s | (err_overrun_r & ~err_clr);
      err_timeout_r <= set_timeout_s | (err_timeout_r & ~err_clr);
    end
  end

  assign cnt_clr     = cnt_clr_r;
  assign cnt_start   = cnt_start_r;
  assign snap        = snap_r;
  assign busy        = busy_r;
  assign seq_num     = seq_num_r;
  assign err_overrun = err_overrun_r;
  assign err_timeout = err_timeout_r;

`ifdef ACQ_SEQ_STIM_EN
  localparam logic [15:0] STIM_LAST = 16'(STIM_DIV - 1);

  logic [15:0] stim_cnt_r;
  logic        stim_pulse_r;
  logic        stim_cond_s;
  logic        stim_hit_s;

  // The divider only runs while counting with the command active, so the
  // first pulse lands STIM_DIV cycles after whichever of the two came last.
  assign stim_cond_s = (state_r == S_COUNT) && stim_cmd;
  assign stim_hit_s  = stim_cond_s && (stim_cnt_r == STIM_LAST);

  // Stimulus divider and registered pulse, suppressed when COUNT is ending.
  always_ff @(posedge clk50 or negedge gse_resetn) begin
    if (!gse_resetn) begin
      stim_cnt_r   <= 16'd0;
      stim_pulse_r <= 1'b0;
    end else begin
      if (!stim_cond_s || stim_hit_s) begin
        stim_cnt_r <= 16'd0;
      end else begin
        stim_cnt_r <= stim_cnt_r + 16'd1;
      end
      stim_pulse_r <= stim_hit_s && (state_nxt == S_COUNT);
    end
  end

  assign stim_pulse = stim_pulse_r;
`else
  logic unused_stim_s;
  assign unused_stim_s = stim_cmd;
  assign stim_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_acq_window_sched.sv
module tb_acq_window_sched;

  localparam int WIN = 10;
  localparam int CLR = 2;
  localparam int TMO = 8;
  localparam int SDV = 4;

  logic       clk50 = 1'b0;
  logic       gse_resetn = 1'b0;
  logic       enable = 1'b0;
  logic       free_run = 1'b0;
  logic       frame_strobe = 1'b0;
  logic       cnt_done = 1'b0;
  logic       stim_cmd = 1'b0;
  logic       err_clr = 1'b0;
  logic       cnt_clr, cnt_start, snap, busy, err_overrun, err_timeout, stim_pulse;
  logic [7:0] seq_num;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] seq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  acq_window_sched #(
    .WIN_CYCLES(WIN), .CLR_CYCLES(CLR), .DONE_TMO(TMO), .STIM_DIV(SDV)
  ) dut (
    .clk50(clk50), .gse_resetn(gse_resetn), .enable(enable), .free_run(free_run),
    .frame_strobe(frame_strobe), .cnt_done(cnt_done), .stim_cmd(stim_cmd),
    .err_clr(err_clr), .cnt_clr(cnt_clr), .cnt_start(cnt_start), .snap(snap),
    .seq_num(seq_num), .busy(busy), .err_overrun(err_overrun),
    .err_timeout(err_timeout), .stim_pulse(stim_pulse)
  );

  always #10 clk50 = ~clk50;

  always @(posedge clk50) cyc <= cyc + 1;

  // Scoreboard monitor: every snap must match the oldest expected snap.
  always @(negedge clk50) begin
    if (gse_resetn && snap) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_snap: cycle %0d seq_num %0d, required no snap", cyc, seq_num);
      end else begin
        mon_e = sb_q.pop_front();
        if (cyc !== mon_e.cyc || seq_num !== mon_e.seq) begin
          errors++;
          $display("FAIL snap_scoreboard: got cycle %0d seq %0d, required cycle %0d seq %0d",
                   cyc, seq_num, mon_e.cyc, mon_e.seq);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_snaps: %0d expected snaps outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    gse_resetn = 1'b0;
    repeat (3) step();
    obs = {cnt_clr, cnt_start, snap, busy, err_overrun, err_timeout, stim_pulse, seq_num};
    checks++;
    if (obs !== 15'd0) begin
      errors++;
      $display("FAIL reset_hold: outputs %b, required all 0", obs);
    end
    gse_resetn = 1'b1;
    enable = 1'b1;
    step();
    obs = {cnt_clr, cnt_start, snap, busy, err_overrun, err_timeout, stim_pulse, seq_num};
    checks++;
    if (obs !== 15'd0) begin
      errors++;
      $display("FAIL reset_release: outputs %b, required all 0", obs);
    end
  endtask

  task automatic test_single_window();
    logic [3:0] obs, exp;
    frame_strobe = 1'b1;
    sb_q.push_back('{cyc: cyc + 14, seq: 8'd1});
    step();
    frame_strobe = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      exp = {(c <= CLR), (c > CLR && c <= CLR + WIN), (c == 14), (c <= 14)};
      obs = {cnt_clr, cnt_start, snap, busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_window_c%0d: clr/start/snap/busy %b, required %b", c, obs, exp);
      end
      if (c == 14) begin
        checks++;
        if (seq_num !== 8'd1) begin
          errors++;
          $display("FAIL single_window_seq: seq_num %0d, required 1", seq_num);
        end
      end
      cnt_done = (c == 13);
      if (c < 15) step();
    end
    cnt_done = 1'b0;
    check_sb_empty("single_window");
  endtask

  task automatic test_free_run_wrap();
    int base;
    base = cyc;
    cnt_done = 1'b1;
    free_run = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      sb_q.push_back('{cyc: base + 14 * k, seq: 8'((1 + k) & 255)});
    end
    for (int i = 1; i <= 14 * 256 + 1; i++) begin
      step();
      if (i == 14 * 256) free_run = 1'b0;
      if (i == 14 * 255) begin
        checks++;
        if (seq_num !== 8'd0 || snap !== 1'b1) begin
          errors++;
          $display("FAIL free_run_wrap: seq_num %0d snap %b, required 0 and 1", seq_num, snap);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || seq_num !== 8'd1) begin
      errors++;
      $display("FAIL free_run_stop: busy %b seq_num %0d, required 0 and 1", busy, seq_num);
    end
    cnt_done = 1'b0;
    check_sb_empty("free_run");
  endtask

  task automatic test_timeout();
    logic [1:0] obs, exp;
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      exp = {(c <= 20), (c >= 21)};
      obs = {busy, err_timeout};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL timeout_c%0d: busy/err_timeout %b, required %b", c, obs, exp);
      end
      if (c < 21) step();
    end
    checks++;
    if (seq_num !== 8'd1) begin
      errors++;
      $display("FAIL timeout_seq: seq_num %0d, required 1", seq_num);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err_timeout %b, required 0", err_timeout);
    end
    check_sb_empty("timeout");
  endtask

  task automatic test_overrun();
    frame_strobe = 1'b1;
    sb_q.push_back('{cyc: cyc + 14, seq: 8'd2});
    step();
    frame_strobe = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      frame_strobe = (c == 5);
      err_clr      = (c == 5) || (c == 7);
      cnt_done     = (c == 13);
      step();
      frame_strobe = 1'b0;
      err_clr      = 1'b0;
      if (c + 1 == 6 || c + 1 == 8) begin
        checks++;
        if (err_overrun !== (c + 1 == 6)) begin
          errors++;
          $display("FAIL overrun_c%0d: err_overrun %b, required %b", c + 1, err_overrun, (c + 1 == 6));
        end
      end
      if (c + 1 >= 15) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL overrun_no_extra_c%0d: busy %b, required 0", c + 1, busy);
        end
      end
    end
    cnt_done = 1'b0;
    check_sb_empty("overrun");
  endtask

  task automatic test_abort_and_reset();
    logic [3:0]  obs, exp;
    logic [14:0] all;
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c <= 6) exp = {(c <= CLR), (c > CLR), 1'b0, 1'b1};
      else        exp = 4'b0000;
      obs = {cnt_clr, cnt_start, snap, busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_c%0d: clr/start/snap/busy %b, required %b", c, obs, exp);
      end
      if (c == 6) enable = 1'b0;
      cnt_done = (c == 9 || c == 10);
      step();
    end
    cnt_done = 1'b0;
    enable   = 1'b1;
    step();
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    checks++;
    if (cnt_clr !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_clear: cnt_clr %b busy %b, required 1 and 1", cnt_clr, busy);
    end
    #2 gse_resetn = 1'b0;
    #1;
    all = {cnt_clr, cnt_start, snap, busy, err_overrun, err_timeout, stim_pulse, seq_num};
    checks++;
    if (all !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: outputs %b, required all 0", all);
    end
    #1 gse_resetn = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || cnt_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_after_release: busy %b cnt_clr %b, required 0 and 0", busy, cnt_clr);
    end
    check_sb_empty("abort");
  endtask

  task automatic test_stim();
    logic exp;
    stim_cmd = 1'b1;
    frame_strobe = 1'b1;
    sb_q.push_back('{cyc: cyc + 14, seq: 8'd1});
    step();
    frame_strobe = 1'b0;
    for (int c = 1; c <= 15; c++) begin
`ifdef ACQ_SEQ_STIM_EN
      exp = (c == CLR + 1 + SDV) || (c == CLR + 1 + 2 * SDV);
`else
      exp = 1'b0;
`endif
      checks++;
      if (stim_pulse !== exp) begin
        errors++;
        $display("FAIL stim_c%0d: stim_pulse %b, required %b", c, stim_pulse, exp);
      end
      cnt_done = (c == 13);
      if (c < 15) step();
    end
    cnt_done = 1'b0;
    stim_cmd = 1'b0;
    check_sb_empty("stim");
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_free_run_wrap();
    test_timeout();
    test_overrun();
    test_abort_and_reset();
    test_stim();
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
